// File: rtl/hart_lsu.sv
// Load/store unit: one access at a time over a valid/ready memory port, with
// byte-lane masking, load extension, decode traps and an optional response timeout.
//
// state | meaning
// IDLE  | ready for a core request; decode and register it on i_req_valid
// REQ   | memory request presented, held stable until i_mem_req_ready
// WAIT  | waiting for i_mem_resp_valid (optionally bounded by TIMEOUT_CYCLES)
// RESP  | one-cycle completion pulse toward the core
module hart_lsu #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_wen,
  input  logic [2:0]            i_req_funct3,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [31:0]           i_req_wdata,
  output logic                  o_resp_valid,
  output logic [31:0]           o_resp_rdata,
  output logic                  o_resp_trap,
  output logic                  o_mem_req_valid,
  input  logic                  i_mem_req_ready,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_wen,
  output logic [31:0]           o_mem_wdata,
  output logic [3:0]            o_mem_mask,
  input  logic                  i_mem_resp_valid,
  input  logic [31:0]           i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_CYCLES);
  localparam bit          TO_EN    = (TIMEOUT_CYCLES > 0);

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            off_q;
  logic                  wen_q;
  logic [31:0]           wdata_q;
  logic [3:0]            mask_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic                  trap_q;
  logic [31:0]           rdata_q;
  logic [31:0]           wait_cnt;

  logic [1:0]  dec_size;
  logic        dec_uns;
  logic        dec_illegal;
  logic        dec_misal;
  logic [3:0]  dec_mask;
  logic        dec_trap;
  logic        timeout_hit;
  logic [31:0] rd_shifted;
  logic [31:0] load_ext;

  // size encoding: 0 = byte, 1 = half, 2 = word
  always_comb begin
    dec_size    = 2'd0;
    dec_uns     = 1'b0;
    dec_illegal = 1'b0;
    case (i_req_funct3)
      3'b000: dec_size = 2'd0;
      3'b001: dec_size = 2'd1;
      3'b010: dec_size = 2'd2;
      3'b100: begin
        dec_size    = 2'd0;
        dec_uns     = 1'b1;
        dec_illegal = i_req_wen;
      end
      3'b101: begin
        dec_size    = 2'd1;
        dec_uns     = 1'b1;
        dec_illegal = i_req_wen;
      end
      default: dec_illegal = 1'b1;
    endcase

    dec_misal = !dec_illegal &&
                ((dec_size == 2'd1 && i_req_addr[0]) ||
                 (dec_size == 2'd2 && i_req_addr[1:0] != 2'b00));

    case (dec_size)
      2'd0:    dec_mask = 4'b0001 << i_req_addr[1:0];
      2'd1:    dec_mask = 4'b0011 << i_req_addr[1:0];
      default: dec_mask = 4'b1111;
    endcase
    if (dec_illegal) dec_mask = 4'b0000;

    dec_trap = dec_illegal || dec_misal;
  end

  // wait_cnt counts the WAIT cycles already spent; this cycle is number wait_cnt+1
  assign timeout_hit = TO_EN && (wait_cnt + 32'd1 == TO_LIMIT);

  always_comb begin
    rd_shifted = i_mem_rdata >> {off_q, 3'b000};
    case (size_q)
      2'd0:    load_ext = uns_q ? {24'd0, rd_shifted[7:0]}
                                : {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      2'd1:    load_ext = uns_q ? {16'd0, rd_shifted[15:0]}
                                : {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      default: load_ext = rd_shifted;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    o_req_ready     = 1'b0;
    o_mem_req_valid = 1'b0;
    o_resp_valid    = 1'b0;
    case (state)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) state_nxt = dec_trap ? RESP : REQ;
      end
      REQ: begin
        o_mem_req_valid = 1'b1;
        if (i_mem_req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (i_mem_resp_valid || timeout_hit) state_nxt = RESP;
      end
      RESP: begin
        o_resp_valid = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q  <= '0;
      off_q   <= 2'b00;
      wen_q   <= 1'b0;
      wdata_q <= 32'd0;
      mask_q  <= 4'b0000;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      trap_q  <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            addr_q  <= {i_req_addr[ADDR_WIDTH-1:2], 2'b00};
            off_q   <= i_req_addr[1:0];
            wen_q   <= i_req_wen;
            wdata_q <= i_req_wdata << {i_req_addr[1:0], 3'b000};
            mask_q  <= dec_mask;
            size_q  <= dec_size;
            uns_q   <= dec_uns;
            trap_q  <= dec_trap;
            rdata_q <= 32'd0;
          end
        end
        WAIT: begin
          // a response on the timeout cycle takes priority over the trap
          if (i_mem_resp_valid) begin
            rdata_q <= wen_q ? 32'd0 : load_ext;
            trap_q  <= 1'b0;
          end else if (timeout_hit) begin
            rdata_q <= 32'd0;
            trap_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      wait_cnt <= 32'd0;
    else if (state == WAIT && !i_mem_resp_valid && !timeout_hit)
      wait_cnt <= wait_cnt + 32'd1;
    else
      wait_cnt <= 32'd0;
  end

  assign o_mem_addr   = addr_q;
  assign o_mem_wen    = wen_q;
  assign o_mem_wdata  = wdata_q;
  assign o_mem_mask   = mask_q;
  assign o_resp_rdata = (state == RESP) ? rdata_q : 32'd0;
  assign o_resp_trap  = (state == RESP) && trap_q;

endmodule
